// File: rtl/load_store_unit_if.sv
// Core-request and data-memory signals of the load/store unit.
// slave: the LSU itself; master: the core/memory side that drives it.
interface load_store_unit_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [2:0]              req_funct3;
  logic [DATA_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic                    resp_valid;
  logic [DATA_WIDTH-1:0]   resp_rdata;
  logic                    resp_err;
  logic                    busy;
  logic                    mem_req;
  logic                    mem_we;
  logic [DATA_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH/8-1:0] mem_be;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH-1:0]   mem_rdata;
  logic                    mem_ack;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata, mem_ack,
    output req_ready, resp_valid, resp_rdata, resp_err, busy,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata, mem_ack,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store stage: one word-aligned memory access per request, faults on misaligned/illegal ops.
// Define LSU_TIMEOUT_EN to abort a request after TIMEOUT_CYCLES cycles without mem_ack.
module load_store_unit #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic              clk,
  input logic              rst,
  load_store_unit_if.slave bus
);
  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  state_e                state_q, state_d;
  logic                  we_q;
  logic [2:0]            funct3_q;
  logic [DATA_WIDTH-1:0] addr_q, wdata_q, rdata_q;
  logic                  err_q;

  logic                  legal, aligned, fault, timeout, ready;
  logic [DATA_WIDTH-1:0] lane, load_data, store_data;
  logic [3:0]            store_be;

  // Decode of the incoming request; only meaningful while idle.
  always_comb begin
    case (bus.req_funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = ~bus.req_we;
      default:                legal = 1'b0;
    endcase
    case (bus.req_funct3[1:0])
      2'b01:   aligned = ~bus.req_addr[0];
      2'b10:   aligned = (bus.req_addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    fault = ~(legal & aligned);
  end

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q;

  // An ack on the limit cycle takes priority over the abort.
  assign timeout = (state_q == StReq) && !bus.mem_ack &&
                   (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || state_q != StReq) begin
      cnt_q <= '0;
    end else if (!bus.mem_ack) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (bus.req_valid) state_d = fault ? StResp : StReq;
      StReq:   if (bus.mem_ack || timeout) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q     <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else if (state_q == StIdle && bus.req_valid) begin
      we_q     <= bus.req_we;
      funct3_q <= bus.req_funct3;
      addr_q   <= bus.req_addr;
      wdata_q  <= bus.req_wdata;
      rdata_q  <= '0;
      err_q    <= fault;
    end else if (state_q == StReq && bus.mem_ack) begin
      rdata_q  <= we_q ? '0 : load_data;
    end else if (timeout) begin
      err_q    <= 1'b1;
    end
  end

  // Lane select and extension of the returned word.
  always_comb begin
    lane = bus.mem_rdata >> {addr_q[1:0], 3'b000};
    case (funct3_q)
      3'b000:  load_data = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_data = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_data = {24'b0, lane[7:0]};
      3'b101:  load_data = {16'b0, lane[15:0]};
      default: load_data = lane;
    endcase
  end

  always_comb begin
    case (funct3_q[1:0])
      2'b00: begin
        store_be   = 4'b0001 << addr_q[1:0];
        store_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        store_be   = addr_q[1] ? 4'b1100 : 4'b0011;
        store_data = {2{wdata_q[15:0]}};
      end
      default: begin
        store_be   = 4'b1111;
        store_data = wdata_q;
      end
    endcase
  end

  always_comb begin
    ready          = (state_q == StIdle) && !rst;
    bus.req_ready  = ready;
    bus.busy       = ~ready;
    bus.mem_req    = (state_q == StReq);
    bus.mem_we     = bus.mem_req & we_q;
    bus.mem_addr   = bus.mem_req ? {addr_q[DATA_WIDTH-1:2], 2'b00} : '0;
    bus.mem_be     = bus.mem_req ? store_be : '0;
    bus.mem_wdata  = bus.mem_we ? store_data : '0;
    bus.resp_valid = (state_q == StResp);
    bus.resp_rdata = rdata_q;
    bus.resp_err   = err_q;
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Randomised bench for load_store_unit against a transaction-level timing/data model.
module tb_load_store_unit;
  localparam int unsigned To = 4;
`ifdef LSU_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if bus ();
  load_store_unit #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(To)) dut (.clk(clk), .rst(rst), .bus(bus));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  // Expected windows, in cycles counted after each posedge.
  int e_acc = -100, e_req_s = -100, e_req_e = -200, e_resp = -100, e_busy_e = -200;
  int ack_cyc = -1;
  logic [31:0] ack_word, e_addr, e_wdata, e_rdata;
  logic [3:0]  e_be;
  logic        e_we, e_err;
  int last_issue;

  // Observations collected by the compare process.
  int n_memreq = 0, n_we = 0, n_resp = 0, last_resp_cyc = 0;
  logic [31:0] last_rdata = '0, last_maddr = '0, last_mwdata = '0;
  logic [3:0]  last_be = '0;
  logic        last_err = 1'b0;
  int snap_memreq, snap_we, snap_resp;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic int m_size(int f3);
    case (f3 % 4)
      0:       return 1;
      1:       return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit m_legal(bit we, int f3);
    if (we) return f3 <= 2;
    return f3 <= 2 || f3 == 4 || f3 == 5;
  endfunction

  function automatic bit m_aligned(int f3, logic [31:0] a);
    return (int'(a[1:0]) % m_size(f3)) == 0;
  endfunction

  function automatic logic [3:0] m_be(int f3, logic [31:0] a);
    return 4'(((1 << m_size(f3)) - 1) << a[1:0]);
  endfunction

  function automatic logic [31:0] m_wdata(int f3, logic [31:0] d);
    case (m_size(f3))
      1:       return (d & 32'hFF) * 32'h0101_0101;
      2:       return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] m_load(int f3, logic [31:0] a, logic [31:0] w);
    int sz;
    logic [31:0] v, span;
    sz = m_size(f3);
    span = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
    v = (w >> (8 * a[1:0])) & span;
    if (sz < 4 && f3 < 4 && v > (span >> 1)) v = v | ~span;
    return v;
  endfunction

  logic in_req, in_resp, exp_rdy;
  always @(negedge clk) begin
    in_req  = (cyc >= e_req_s) && (cyc <= e_req_e);
    in_resp = (cyc == e_resp);
    exp_rdy = !rst && !((cyc >= e_acc) && (cyc <= e_busy_e));
    chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    chk("busy", 32'(bus.busy), 32'(!exp_rdy));
    chk("mem_req", 32'(bus.mem_req), 32'(in_req));
    chk("resp_valid", 32'(bus.resp_valid), 32'(in_resp));
    if (in_req) begin
      chk("mem_addr", bus.mem_addr, e_addr);
      chk("mem_be", 32'(bus.mem_be), 32'(e_be));
      chk("mem_we", 32'(bus.mem_we), 32'(e_we));
      if (e_we) chk("mem_wdata", bus.mem_wdata, e_wdata);
    end
    if (in_resp) begin
      chk("resp_err", 32'(bus.resp_err), 32'(e_err));
      chk("resp_rdata", bus.resp_rdata, e_rdata);
    end
    if (bus.mem_req) begin
      n_memreq++;
      last_maddr = bus.mem_addr;
      last_be = bus.mem_be;
      last_mwdata = bus.mem_wdata;
      if (bus.mem_we) n_we++;
    end
    if (bus.resp_valid) begin
      n_resp++;
      last_resp_cyc = cyc;
      last_rdata = bus.resp_rdata;
      last_err = bus.resp_err;
    end
  end

  // Memory side: ack on the model's chosen cycle, stray acks only outside REQ.
  task automatic tick();
    @(posedge clk);
    #1;
    bus.mem_ack = (cyc == ack_cyc);
    bus.mem_rdata = (cyc == ack_cyc) ? ack_word : $urandom();
    if (!bus.mem_ack && !((cyc >= e_req_s) && (cyc <= e_req_e)))
      bus.mem_ack = ($urandom_range(0, 3) == 0);
  endtask

  // Called at #1 into an idle cycle; returns one cycle after the response.
  task automatic issue(input bit we, input int f3, input logic [31:0] a, input logic [31:0] d,
                       input int waits, input logic [31:0] word);
    int n;
    n = cyc + 1;
    last_issue = cyc;
    snap_memreq = n_memreq;
    snap_we = n_we;
    snap_resp = n_resp;
    e_acc = n;
    e_we = we;
    e_addr = {a[31:2], 2'b00};
    e_be = m_be(f3, a);
    e_wdata = m_wdata(f3, d);
    e_req_s = n;
    if (!(m_legal(we, f3) && m_aligned(f3, a))) begin
      e_req_e = n - 1; e_resp = n; e_err = 1'b1; e_rdata = '0; ack_cyc = -1;
    end else if (TimeoutEn && (waits < 0 || waits >= int'(To))) begin
      e_req_e = n + int'(To) - 1; e_resp = n + int'(To); e_err = 1'b1; e_rdata = '0;
      ack_cyc = -1;
    end else begin
      e_req_e = n + waits; e_resp = n + waits + 1; e_err = 1'b0;
      e_rdata = we ? '0 : m_load(f3, a, word);
      ack_cyc = n + waits; ack_word = word;
    end
    e_busy_e = e_resp;
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_funct3 = 3'(f3);
    bus.req_addr = a;
    bus.req_wdata = d;
    tick();
    // Held request with changing fields must not disturb the latched access.
    while (cyc <= e_busy_e) begin
      bus.req_we = 1'($urandom());
      bus.req_funct3 = 3'($urandom());
      bus.req_addr = $urandom();
      bus.req_wdata = $urandom();
      tick();
    end
    bus.req_valid = 1'b0;
  endtask

  initial begin
    int n;
    bit we;
    int f3;
    logic [31:0] a;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = '0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.mem_rdata = '0; bus.mem_ack = 1'b0;

    chk("model_lb", m_load(0, 32'h103, 32'h80FF_FFFF), 32'hFFFF_FF80);
    chk("model_lbu", m_load(4, 32'h103, 32'h80FF_FFFF), 32'h0000_0080);
    chk("model_sh_wdata", m_wdata(1, 32'h1234_ABCD), 32'hABCD_ABCD);
    chk("model_sh_be", 32'(m_be(1, 32'h202)), 32'hC);

    repeat (3) tick();
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd1);
    chk("rst_mem", {bus.mem_req, bus.mem_we, bus.mem_be, 24'(bus.mem_addr | bus.mem_wdata)}, 32'd0);
    chk("rst_resp", {bus.resp_valid, bus.resp_err, 30'(bus.resp_rdata)}, 32'd0);
    rst = 1'b0;
    tick();

    issue(1'b0, 2, 32'h100, 32'h0, 0, 32'hDEAD_BEEF);
    chk("lw_rdata", last_rdata, 32'hDEAD_BEEF);
    chk("lw_err", 32'(last_err), 32'd0);
    chk("lw_be", 32'(last_be), 32'hF);
    chk("lw_latency", 32'(last_resp_cyc - last_issue), 32'd2);

    issue(1'b0, 0, 32'h103, 32'h0, 1, 32'h80FF_FFFF);
    chk("lb_rdata", last_rdata, 32'hFFFF_FF80);
    issue(1'b0, 4, 32'h103, 32'h0, 0, 32'h80FF_FFFF);
    chk("lbu_rdata", last_rdata, 32'h0000_0080);

    issue(1'b1, 1, 32'h202, 32'h1234_ABCD, 3, 32'h5555_5555);
    chk("sh_addr", last_maddr, 32'h200);
    chk("sh_be", 32'(last_be), 32'hC);
    chk("sh_wdata", last_mwdata, 32'hABCD_ABCD);
    chk("sh_we_cycles", 32'(n_we - snap_we), 32'd4);
    chk("sh_rdata", last_rdata, 32'd0);

    issue(1'b0, 2, 32'h101, 32'h0, 0, 32'h1);
    chk("mis_memreq", 32'(n_memreq - snap_memreq), 32'd0);
    chk("mis_err", 32'(last_err), 32'd1);
    chk("mis_latency", 32'(last_resp_cyc - last_issue), 32'd1);
    issue(1'b0, 3, 32'h100, 32'h0, 0, 32'h1);
    chk("ill_memreq", 32'(n_memreq - snap_memreq), 32'd0);
    chk("ill_err", 32'(last_err), 32'd1);

    // Stalled LW, reset during its second REQ cycle.
    n = cyc + 1;
    snap_resp = n_resp;
    e_acc = n; e_req_s = n; e_req_e = n + 1; e_resp = -100; e_busy_e = n + 1;
    ack_cyc = -1; e_we = 1'b0; e_addr = 32'h300; e_be = 4'hF;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'd2; bus.req_addr = 32'h300;
    tick();
    bus.req_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("rst_mid_no_resp", 32'(n_resp - snap_resp), 32'd0);
    issue(1'b0, 2, 32'h304, 32'h0, 1, 32'hCAFE_F00D);
    chk("post_rst_rdata", last_rdata, 32'hCAFE_F00D);

`ifdef LSU_TIMEOUT_EN
    issue(1'b0, 2, 32'h400, 32'h0, -1, 32'h0);
    chk("to_err", 32'(last_err), 32'd1);
    chk("to_memreq", 32'(n_memreq - snap_memreq), 32'd4);
    issue(1'b0, 2, 32'h400, 32'h0, 3, 32'h1357_9BDF);
    chk("to_edge_err", 32'(last_err), 32'd0);
    chk("to_edge_rdata", last_rdata, 32'h1357_9BDF);
`endif

    for (int i = 0; i < 300; i++) begin
      we = 1'($urandom());
      f3 = int'($urandom_range(0, 7));
      a = $urandom();
      if ($urandom_range(0, 3) != 0) a = a & ~32'(m_size(f3) - 1);
      issue(we, f3, a, $urandom(), int'($urandom_range(0, 5)), $urandom());
      if ($urandom_range(0, 1) == 0) tick();
    end
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
